// File: rtl/us_scheduler.sv
// us_scheduler: round-robin trigger/echo timing for three ultrasonic rangers, echo width to mm by repeated subtract.
// Define US_MEDIAN_EN to publish the median of each sensor's last three raw results instead of the raw result.
module us_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GAP_CYCLES     = 100_000,
    parameter int CYC_PER_MM     = 292,
    parameter int THRESH_MM      = 150
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  echo,
    output logic [2:0]  trig,
    output logic [15:0] dist_left,
    output logic [15:0] dist_right,
    output logic [15:0] dist_front,
    output logic        op_left,
    output logic        op_right,
    output logic        op_front,
    output logic        meas_valid,
    output logic [1:0]  meas_idx,
    output logic        timeout
);
    localparam int MAX_TG = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int MAXC   = MAX_TG > TRIG_CYCLES ? MAX_TG : TRIG_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int SW     = $clog2(CYC_PER_MM + 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_sub;
    logic [15:0]   r_mm;
    logic [2:0]    r_trig;
    logic [2:0]    r_sync1, r_sync2, r_sync3;
    logic [15:0]   r_dist [3];
    logic [2:0]    r_op;
    logic          r_valid, r_timeout;
    logic [1:0]    r_midx;

    logic          w_rise, w_fall, w_tmo, w_sub_wrap, w_done_ok, w_done_to, w_wr;
    logic [15:0]   w_mm_next, w_res;
    logic          w_pub_wr, w_pub_to;
    logic [1:0]    w_pub_idx;
    logic [15:0]   w_pub_val;

    // Only the selected sensor's synchronized echo is ever looked at.
    always_comb begin
        w_rise     = r_sync2[r_idx] & ~r_sync3[r_idx];
        w_fall     = ~r_sync2[r_idx] & r_sync3[r_idx];
        w_tmo      = r_cnt == CW'(TIMEOUT_CYCLES - 1);
        w_sub_wrap = r_sub == SW'(CYC_PER_MM - 1);
        w_mm_next  = (w_sub_wrap && r_mm != 16'hFFFE) ? r_mm + 16'd1 : r_mm;
        w_done_ok  = r_state == MEASURE && w_fall;
        w_done_to  = w_tmo && (r_state == WAIT_RISE || (r_state == MEASURE && !w_fall));
        w_wr       = w_done_ok | w_done_to;
        w_res      = w_done_ok ? w_mm_next : 16'hFFFF;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_sub   <= '0;
            r_mm    <= 16'd0;
            r_trig  <= 3'b000;
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_sync3 <= 3'b000;
        end else begin
            r_sync1 <= echo;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            case (r_state)
                IDLE: if (enable) begin
                    r_state <= TRIG;
                    r_cnt   <= '0;
                end
                TRIG: if (r_cnt == CW'(TRIG_CYCLES)) begin
                    r_trig  <= 3'b000;
                    r_state <= WAIT_RISE;
                    r_cnt   <= '0;
                end else begin
                    r_trig <= 3'b001 << r_idx;
                    r_cnt  <= r_cnt + CW'(1);
                end
                WAIT_RISE: if (w_done_to) begin
                    r_state <= GAP;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_mm    <= 16'd0;
                        r_sub   <= '0;
                    end
                end
                // The fall cycle itself is counted: w_res already includes it.
                MEASURE: if (w_wr) begin
                    r_state <= GAP;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    r_sub <= w_sub_wrap ? '0 : r_sub + SW'(1);
                    r_mm  <= w_mm_next;
                end
                GAP: if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    r_idx   <= r_idx == 2'd2 ? 2'd0 : r_idx + 2'd1;
                    r_state <= enable ? TRIG : IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef US_MEDIAN_EN
    logic        r_pend, r_pto;
    logic [1:0]  r_pidx;
    logic [15:0] r_pval;
    logic [15:0] r_h0 [3];
    logic [15:0] r_h1 [3];
    logic [15:0] w_lo, w_hi;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_pto  <= 1'b0;
            r_pidx <= 2'd0;
            r_pval <= 16'hFFFF;
            for (int i = 0; i < 3; i++) begin
                r_h0[i] <= 16'hFFFF;
                r_h1[i] <= 16'hFFFF;
            end
        end else begin
            r_pend <= w_wr;
            r_pto  <= w_done_to;
            r_pidx <= r_idx;
            r_pval <= w_res;
            if (r_pend) begin
                r_h0[r_pidx] <= r_pval;
                r_h1[r_pidx] <= r_h0[r_pidx];
            end
        end
    end

    always_comb begin
        w_lo      = r_h0[r_pidx] < r_h1[r_pidx] ? r_h0[r_pidx] : r_h1[r_pidx];
        w_hi      = r_h0[r_pidx] < r_h1[r_pidx] ? r_h1[r_pidx] : r_h0[r_pidx];
        w_pub_val = r_pval < w_lo ? w_lo : (r_pval > w_hi ? w_hi : r_pval);
    end

    assign w_pub_wr  = r_pend;
    assign w_pub_to  = r_pto;
    assign w_pub_idx = r_pidx;
`else
    assign w_pub_wr  = w_wr;
    assign w_pub_to  = w_done_to;
    assign w_pub_idx = r_idx;
    assign w_pub_val = w_res;
`endif

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_dist[i] <= 16'hFFFF;
            r_op      <= 3'b000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_midx    <= 2'd0;
        end else begin
            r_valid   <= w_pub_wr;
            r_timeout <= w_pub_wr & w_pub_to;
            if (w_pub_wr) begin
                r_dist[w_pub_idx] <= w_pub_val;
                r_op[w_pub_idx]   <= w_pub_val != 16'hFFFF && w_pub_val < 16'(THRESH_MM);
                r_midx            <= w_pub_idx;
            end
        end
    end

    assign trig       = r_trig;
    assign dist_left  = r_dist[0];
    assign dist_right = r_dist[1];
    assign dist_front = r_dist[2];
    assign op_left    = r_op[0];
    assign op_right   = r_op[1];
    assign op_front   = r_op[2];
    assign meas_valid = r_valid;
    assign meas_idx   = r_midx;
    assign timeout    = r_timeout;
endmodule

// File: doc/us_scheduler.md
Name: us_scheduler

Overview:
Time-multiplexed controller for the robot's three ultrasonic rangers (left, right, front).
- Fires one trigger at a time in fixed round-robin order, so no sensor hears another's echo.
- Measures echo pulse width and converts it to millimetres with a repeated-subtract counter (no divider).
- Publishes per-sensor distances and obstacle flags to the motor driver and end-recognition logic.
- Sits between the echo/trig pins and the navigation logic, on clk_50M.

Parameters:
TRIG_CYCLES, 500, trigger high time in clocks (10 us @ 50 MHz)
TIMEOUT_CYCLES, 1_500_000, max clocks from trigger fall to echo fall (30 ms)
GAP_CYCLES, 100_000, settle time between slots (2 ms)
CYC_PER_MM, 292, clocks of echo-high per mm of range
THRESH_MM, 150, obstacle threshold in mm

Ports:
clk_50M  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  run scheduling; sampled at slot boundaries only
echo  in  3  echo pins [0]=left [1]=right [2]=front; asynchronous
trig  out  3  trigger pins, same index map
dist_left  out  16  last left distance, mm; 16'hFFFF = no echo
dist_right  out  16  last right distance, mm
dist_front  out  16  last front distance, mm
op_left  out  1  1 when dist_left < THRESH_MM
op_right  out  1  1 when dist_right < THRESH_MM
op_front  out  1  1 when dist_front < THRESH_MM
meas_valid  out  1  one-cycle pulse when a slot result is written
meas_idx  out  2  sensor index of the result; valid with meas_valid
timeout  out  1  one-cycle pulse, coincident with meas_valid, when the result is a timeout

Behaviour:
- Reset (async, active-high) sets: state IDLE, idx=0, trig=0, all dist=16'hFFFF, all op=0, meas_valid=0, timeout=0, meas_idx=0. Reset mid-slot aborts it with no result written.
- Echo inputs pass through a 2-FF synchronizer; edge detect runs on the synchronized value.
- FSM states:
  - IDLE: if enable, go to TRIG.
  - TRIG: trig[idx]=1 for exactly TRIG_CYCLES clocks, then trig=0 and go to WAIT_RISE. Timeout counter clears on entry to WAIT_RISE.
  - WAIT_RISE: a synced rising edge goes to MEASURE, clearing mm=0 and sub=0. Echo already high on entry is not an edge; a stuck-high echo therefore times out.
  - MEASURE: each clock sub++. When sub==CYC_PER_MM-1, sub=0 and mm++. mm saturates at 16'hFFFE. A synced falling edge writes dist[idx]=mm and goes to GAP.
  - Timeout: in WAIT_RISE or MEASURE, timeout counter reaching TIMEOUT_CYCLES writes dist[idx]=16'hFFFF, pulses timeout, and goes to GAP.
  - GAP: wait GAP_CYCLES, then idx = (idx==2) ? 0 : idx+1. Go to TRIG if enable, else IDLE.
- Result write: dist, op, meas_valid and meas_idx update in the same cycle. That is 1 clock after the synced falling edge, or 3 clocks after the raw echo fall.
- op_x = (dist_x != 16'hFFFF) && (dist_x < THRESH_MM). Registered, updated only on a write.
- Deasserting enable mid-slot completes the current slot, then enters IDLE. Re-enable resumes at the next idx; order is never reset except by reset.
- Only one trig bit is ever high. The echo of a non-selected sensor is ignored.
- Distance outputs hold their value between writes.

Optional Feature:
US_MEDIAN_EN
- Defined: each sensor keeps a 3-deep history of raw results (reset to 16'hFFFF). On write, the new sample is shifted in and dist_x = median of the 3 entries; op_x is computed from the filtered value. Write latency rises by 1 clock (meas_valid delayed to match). timeout still reflects the raw sample.
- Undefined: dist_x = raw result. No history registers.

Test Plan:
- Reset check: after reset, trig=000, all dist=16'hFFFF, all op=0. With enable=1, trig[0] rises 2 clocks after reset release and stays high for 500 clocks.
- Echo measurement: left echo rises 1000 clocks after trig fall and stays high 29_200 clocks -> dist_left=100, op_left=1, meas_valid with meas_idx=0, 3 clocks after echo fall.
- Round-robin and wrap: apply echoes of 58_400 / 14_600 / 87_600 clocks for idx 0,1,2 -> dist 200/50/300, op 0/1/0; the next trigger is trig[0].
- Timeout: no echo on right -> dist_right=16'hFFFF, timeout=1 and meas_valid=1 at TIMEOUT_CYCLES after trig fall, op_right=0. Echo held high from before trigger also times out.
- Enable mid-slot: deassert enable during MEASURE of idx 1 -> result is still written, FSM enters IDLE after GAP. Re-enable -> trig[2] fires.
- Median filter (US_MEDIAN_EN defined): front samples 100, 900, 110 -> dist_front sequence 16'hFFFF, 900, 110. Reset asserted mid-MEASURE -> no write, trig=0 immediately.
